uart_rx_pkt_ctrl: RTL and testbench
===================================

Name: uart_rx_pkt_ctrl

Overview:
- Sequences the UART receiver's byte stream into framed packets.
- Consumes the receiver's Data/rx_done byte strobe and validates header, command, length and checksum.
- Buffers the payload and releases it on a valid/ready stream only after the checksum passes.
- Executes the baud-set command by driving the receiver's Baud_set input, so the host can reconfigure the link in-band.

Parameters:
- HEADER, 8'hA5, frame start byte.
- MAX_LEN, 16, maximum payload bytes (1..255).
- TIMEOUT_CYC, 100000, sysclk cycles allowed between bytes inside a frame.

Ports:
- sysclk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx_data  in  8  received byte from the receiver.
- rx_done  in  1  one-cycle strobe; rx_data valid.
- baud_set  out  3  to receiver Baud_set; 0=115200, 1=9600 (325), 2=651 setting.
- baud_chg  out  1  one-cycle pulse when baud_set is updated.
- pkt_data  out  8  payload byte.
- pkt_valid  out  1  payload byte available.
- pkt_last  out  1  qualifies the final payload byte.
- pkt_ready  in  1  downstream accepts the byte when pkt_valid&pkt_ready.
- pkt_ok  out  1  one-cycle pulse: frame accepted.
- pkt_err  out  1  one-cycle pulse: frame rejected.
- err_code  out  3  valid with pkt_err: 1 bad length, 2 bad checksum, 3 timeout, 4 bad command.
- overrun_cnt  out  8  saturating count of bytes dropped in DRAIN.

Behaviour:
- Reset (rst=1 at sysclk edge): state IDLE, baud_set=0, and all pulses, pkt_valid, pkt_last, pkt_data, err_code and overrun_cnt are 0.
- Frame format: HEADER, CMD, LEN, LEN payload bytes, CHK.
  - Valid when (CMD+LEN+sum(payload)+CHK) mod 256 == 0, using an 8-bit wrapping accumulator.
- States: IDLE, CMD, LEN, PAYLOAD, CHK, DRAIN. All transitions occur on a cycle with rx_done=1 unless noted.
- IDLE: rx_data==HEADER goes to CMD and clears the accumulator. Other bytes are ignored silently with no error.
- CMD: 8'h01 (DATA) or 8'h02 (BAUD) is stored and added to the accumulator, then goes to LEN. Any other value raises err 4 and returns to IDLE.
- LEN:
  - DATA with LEN>MAX_LEN, or BAUD with LEN!=1, raises err 1 and returns to IDLE.
  - LEN=0 goes directly to CHK.
  - Otherwise the byte is added and the state goes to PAYLOAD.
- PAYLOAD: each byte is written to buffer[wr_ptr] and added to the accumulator. When wr_ptr==LEN-1 the state goes to CHK.
- CHK:
  - Checksum bad: err 2, return to IDLE.
  - Good DATA with LEN>0: pkt_ok pulse, go to DRAIN.
  - Good DATA with LEN=0: pkt_ok pulse, go to IDLE.
  - Good BAUD: pkt_ok pulse. On the next cycle baud_set<=buffer[0][2:0] and baud_chg pulses, with values 3..7 mapped to 0. Then return to IDLE.
- DRAIN:
  - pkt_valid=1, pkt_data=buffer[rd_ptr], pkt_last=(rd_ptr==LEN-1).
  - rd_ptr advances on each handshake. The state goes to IDLE on the handshake where pkt_last=1.
  - pkt_data and pkt_last hold stable while pkt_valid&!pkt_ready.
  - An rx_done in DRAIN drops the byte and increments overrun_cnt (saturating at 255). DRAIN has no timeout.
- Timeout: an idle counter clears on every rx_done and in IDLE/DRAIN. In CMD/LEN/PAYLOAD/CHK, reaching TIMEOUT_CYC-1 raises err 3 and returns to IDLE.
  - If rx_done coincides with the terminal count, rx_done wins and the byte is processed.
- A HEADER value seen inside a frame is treated as ordinary data; there is no resync.
- pkt_err and pkt_ok are never asserted in the same cycle. err_code holds its last value until the next pkt_err.
- Reset mid-frame or mid-DRAIN discards the buffer and returns to IDLE with baud_set=0.

Decomposition:
- Package uart_pkt_pkg: state enum, CMD_DATA=8'h01, CMD_BAUD=8'h02, ERR_* codes, default HEADER.
- Sub-module uart_pkt_buf: MAX_LEN x 8 register buffer with write port (we, waddr) and asynchronous read port (raddr).
- The FSM, accumulator, pointers and timeout counter stay in uart_rx_pkt_ctrl.

Test Plan:
- Send A5 01 02 10 20 CD with pkt_ready=1 -> pkt_ok once; stream 10, then 20 with pkt_last=1; no pkt_err.
- Send A5 02 01 01 FC -> pkt_ok, then next cycle baud_set=1 and baud_chg pulse; pkt_valid stays 0.
- Send A5 01 02 10 20 CE -> pkt_err with err_code=2; no pkt_valid. Then A5 07 -> pkt_err with err_code=4.
- Send A5 01 11 (LEN 17 > MAX_LEN) -> err_code=1 immediately after the LEN byte. Send A5 01 followed by silence for TIMEOUT_CYC cycles -> err_code=3.
- Send a 3-byte DATA frame with pkt_ready=0, then inject 2 rx_done bytes -> pkt_data holds the first byte; overrun_cnt=2. Release ready -> all 3 bytes delivered.
- Assert rst during PAYLOAD after a prior baud change -> all outputs return to reset values with baud_set=0. A following valid frame is accepted normally.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet controller.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam logic [7:0] CMD_DATA       = 8'h01;
  localparam logic [7:0] CMD_BAUD       = 8'h02;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CHK     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_CMD     = 3'd4;

  // Receiver only knows settings 0..2; anything else falls back to 115200.
  function automatic logic [2:0] baud_map(input logic [7:0] b);
    return (b[2:0] > 3'd2) ? 3'd0 : b[2:0];
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: registered write port, asynchronous read port.
module uart_pkt_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames the UART byte stream into checksummed packets, streams accepted
// payloads out and applies in-band baud-rate changes.
module uart_rx_pkt_ctrl
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [2:0] baud_set,
  output logic       baud_chg,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_last,
  input  logic       pkt_ready,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [2:0] err_code,
  output logic [7:0] overrun_cnt
);

  localparam int             AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  state_e        state_q, state_d;
  logic [7:0]    acc_q, cmd_q, len_q, wr_ptr_q, rd_ptr_q;
  logic [TW-1:0] tmo_q;
  logic          baud_pend_q, baud_pend_d;
  logic [2:0]    baud_set_q, err_code_q, err_code_d;
  logic          baud_chg_q, pkt_ok_q, pkt_ok_d, pkt_err_q, pkt_err_d;
  logic [7:0]    overrun_q;
  logic [7:0]    buf_rdata, chk_sum;
  logic          buf_we, in_frame, tmo_hit, hs, last_rd, len_bad, cmd_ok;

  assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                    (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  // A byte arriving on the terminal count takes priority over the timeout.
  assign tmo_hit  = in_frame && !rx_done && (tmo_q == TMO_LAST);
  assign hs       = (state_q == ST_DRAIN) && pkt_ready;
  assign last_rd  = (rd_ptr_q == len_q - 8'd1);
  assign chk_sum  = acc_q + rx_data;
  assign cmd_ok   = (rx_data == CMD_DATA) || (rx_data == CMD_BAUD);
  assign len_bad  = ((cmd_q == CMD_DATA) && (rx_data > MAX_LEN_B)) ||
                    ((cmd_q == CMD_BAUD) && (rx_data != 8'd1));
  assign buf_we   = (state_q == ST_PAYLOAD) && rx_done;

  uart_pkt_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk   (sysclk),
    .we    (buf_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  always_ff @(posedge sysclk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (rx_done && rx_data == HEADER) state_d = ST_CMD;
      ST_CMD:     if (rx_done) state_d = cmd_ok ? ST_LEN : ST_IDLE;
      ST_LEN:     if (rx_done) state_d = len_bad ? ST_IDLE :
                                         (rx_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
      ST_PAYLOAD: if (rx_done && wr_ptr_q == len_q - 8'd1) state_d = ST_CHK;
      ST_CHK:     if (rx_done) state_d = (chk_sum == 8'd0 && cmd_q == CMD_DATA &&
                                          len_q != 8'd0) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:   if (hs && last_rd) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (tmo_hit) state_d = ST_IDLE;
  end

  always_comb begin
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    baud_pend_d = 1'b0;
    if (rx_done) begin
      unique case (state_q)
        ST_CMD: if (!cmd_ok) begin pkt_err_d = 1'b1; err_code_d = ERR_CMD; end
        ST_LEN: if (len_bad) begin pkt_err_d = 1'b1; err_code_d = ERR_LEN; end
        ST_CHK: begin
          if (chk_sum == 8'd0) begin
            pkt_ok_d    = 1'b1;
            baud_pend_d = (cmd_q == CMD_BAUD);
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_CHK;
          end
        end
        default: ;
      endcase
    end
    if (tmo_hit) begin
      pkt_err_d  = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  // Frame data path: accumulator, command and length carry no reset.
  always_ff @(posedge sysclk) begin
    if (rx_done) begin
      case (state_q)
        ST_IDLE:    acc_q <= 8'd0;
        ST_CMD:     begin acc_q <= chk_sum; cmd_q <= rx_data; end
        ST_LEN:     begin acc_q <= chk_sum; len_q <= rx_data; end
        ST_PAYLOAD: acc_q <= chk_sum;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      wr_ptr_q    <= 8'd0;
      rd_ptr_q    <= 8'd0;
      tmo_q       <= '0;
      baud_pend_q <= 1'b0;
      baud_set_q  <= 3'd0;
      baud_chg_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
      overrun_q   <= 8'd0;
    end else begin
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      baud_pend_q <= baud_pend_d;
      baud_chg_q  <= baud_pend_q;
      // rd_ptr is parked at 0 outside DRAIN, so the read port shows buffer[0].
      if (baud_pend_q) baud_set_q <= baud_map(buf_rdata);
      if (rx_done || !in_frame) tmo_q <= '0;
      else                      tmo_q <= tmo_q + TW'(1);
      if (state_q == ST_LEN && rx_done) wr_ptr_q <= 8'd0;
      else if (buf_we)                  wr_ptr_q <= wr_ptr_q + 8'd1;
      if (hs) rd_ptr_q <= last_rd ? 8'd0 : rd_ptr_q + 8'd1;
      if (state_q == ST_DRAIN && rx_done && overrun_q != 8'hFF)
        overrun_q <= overrun_q + 8'd1;
    end
  end

  assign pkt_valid   = (state_q == ST_DRAIN);
  assign pkt_data    = pkt_valid ? buf_rdata : 8'h00;
  assign pkt_last    = pkt_valid && last_rd;
  assign baud_set    = baud_set_q;
  assign baud_chg    = baud_chg_q;
  assign pkt_ok      = pkt_ok_q;
  assign pkt_err     = pkt_err_q;
  assign err_code    = err_code_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl: directed frame table, multi-cycle
// corner sequences and randomized frames against a frame-level model.
module tb_uart_rx_pkt_ctrl;

  localparam int TMO = 64;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done = 1'b0;
  logic       pkt_ready = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic [2:0] baud_set, err_code;
  logic       baud_chg, pkt_valid, pkt_last, pkt_ok, pkt_err;
  logic [7:0] pkt_data, overrun_cnt;

  always #5 sysclk = ~sysclk;

  uart_rx_pkt_ctrl #(.HEADER(8'hA5), .MAX_LEN(16), .TIMEOUT_CYC(TMO)) dut (
    .sysclk(sysclk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .baud_set(baud_set), .baud_chg(baud_chg), .pkt_data(pkt_data),
    .pkt_valid(pkt_valid), .pkt_last(pkt_last), .pkt_ready(pkt_ready),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code),
    .overrun_cnt(overrun_cnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Event capture, sampled on the falling edge.
  logic [7:0] cap_data[$];
  bit         cap_last[$];
  logic [2:0] cap_code[$];
  logic [2:0] cap_baud[$];
  int n_ok = 0, ok_cyc = -1, chg_cyc = -1, err_cyc = -1, rx_cyc = -1;

  always @(negedge sysclk) begin
    if (rx_done) rx_cyc = cyc;
    if (pkt_ok) begin n_ok++; ok_cyc = cyc; end
    if (pkt_err) begin cap_code.push_back(err_code); err_cyc = cyc; end
    if (pkt_ok && pkt_err) begin
      fails++;
      $display("FAIL ok_err_excl: both pulses high at cycle %0d", cyc);
    end
    if (pkt_valid && pkt_ready) begin
      cap_data.push_back(pkt_data);
      cap_last.push_back(pkt_last);
    end
    if (baud_chg) begin cap_baud.push_back(baud_set); chg_cyc = cyc; end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    tick(1);
  endtask

  task automatic clear_caps();
    cap_data.delete(); cap_last.delete(); cap_code.delete(); cap_baud.delete();
    n_ok = 0; ok_cyc = -1; chg_cyc = -1; err_cyc = -1;
  endtask

  function automatic logic [31:0] outs_flat();
    return {1'b0, baud_set, baud_chg, pkt_valid, pkt_last, pkt_ok, pkt_err,
            err_code, pkt_data, overrun_cnt};
  endfunction

  // Directed vectors: bytes are MSB-first in b.
  typedef struct {
    int          n;
    logic [63:0] b;
    int          exp_ok;
    int          exp_code;
    int          exp_nd;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          exp_baud;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6, {8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'hCD, 16'h0}, 1, 0, 2, 8'h10, 8'h20, -1};
    vecs[1] = '{5, {8'hA5, 8'h02, 8'h01, 8'h01, 8'hFC, 24'h0}, 1, 0, 0, 8'h00, 8'h00, 1};
    vecs[2] = '{6, {8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'hCE, 16'h0}, 0, 2, 0, 8'h00, 8'h00, -1};
    vecs[3] = '{2, {8'hA5, 8'h07, 48'h0}, 0, 4, 0, 8'h00, 8'h00, -1};
    vecs[4] = '{3, {8'hA5, 8'h01, 8'h11, 40'h0}, 0, 1, 0, 8'h00, 8'h00, -1};
    vecs[5] = '{4, {8'hA5, 8'h01, 8'h00, 8'hFF, 32'h0}, 1, 0, 0, 8'h00, 8'h00, -1};
    vecs[6] = '{3, {8'hA5, 8'h02, 8'h02, 40'h0}, 0, 1, 0, 8'h00, 8'h00, -1};
    vecs[7] = '{6, {8'h33, 8'hA5, 8'h02, 8'h01, 8'h05, 8'hF8, 16'h0}, 1, 0, 0, 8'h00, 8'h00, 0};
    vecs[8] = '{5, {8'hA5, 8'h02, 8'h01, 8'h02, 8'hFB, 24'h0}, 1, 0, 0, 8'h00, 8'h00, 2};
    vecs[9] = '{5, {8'hA5, 8'h01, 8'h01, 8'hA5, 8'h59, 24'h0}, 1, 0, 1, 8'hA5, 8'h00, -1};

    tick(3);
    check("reset_outputs", outs_flat(), 32'h0);
    rst = 1'b0;
    tick(2);

    for (int v = 0; v < 10; v++) begin
      clear_caps();
      for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[63-8*i -: 8]);
      tick(25);
      check($sformatf("vec%0d_ok", v), n_ok, vecs[v].exp_ok);
      check($sformatf("vec%0d_nerr", v), cap_code.size(), (vecs[v].exp_code != 0) ? 1 : 0);
      if (vecs[v].exp_code != 0 && cap_code.size() > 0)
        check($sformatf("vec%0d_code", v), cap_code[0], vecs[v].exp_code);
      check($sformatf("vec%0d_ndata", v), cap_data.size(), vecs[v].exp_nd);
      if (vecs[v].exp_nd >= 1 && cap_data.size() >= 1) begin
        check($sformatf("vec%0d_d0", v), cap_data[0], vecs[v].d0);
        check($sformatf("vec%0d_last0", v), cap_last[0], (vecs[v].exp_nd == 1) ? 1 : 0);
      end
      if (vecs[v].exp_nd >= 2 && cap_data.size() >= 2) begin
        check($sformatf("vec%0d_d1", v), cap_data[1], vecs[v].d1);
        check($sformatf("vec%0d_last1", v), cap_last[1], 1);
      end
      if (vecs[v].exp_baud >= 0) begin
        check($sformatf("vec%0d_nbaud", v), cap_baud.size(), 1);
        if (cap_baud.size() > 0) check($sformatf("vec%0d_baud", v), cap_baud[0], vecs[v].exp_baud);
        check($sformatf("vec%0d_baud_lat", v), chg_cyc - ok_cyc, 1);
        check($sformatf("vec%0d_baud_hold", v), baud_set, vecs[v].exp_baud);
      end else begin
        check($sformatf("vec%0d_nbaud", v), cap_baud.size(), 0);
      end
    end
    check("err_code_hold", err_code, 3'd1);

    // Timeout: header and command, then silence.
    clear_caps();
    send_byte(8'hA5);
    send_byte(8'h01);
    begin
      int start, waited;
      start = rx_cyc;
      waited = 0;
      while (cap_code.size() == 0 && waited < 3 * TMO) begin tick(1); waited++; end
      check("tmo_nerr", cap_code.size(), 1);
      if (cap_code.size() > 0) check("tmo_code", cap_code[0], 3'd3);
      check("tmo_latency", ((err_cyc - start) >= TMO) && ((err_cyc - start) <= TMO + 2), 1);
    end

    // Backpressure with overrun bytes arriving during DRAIN.
    tick(3);
    clear_caps();
    pkt_ready = 1'b0;
    foreach (vecs[0].b[i]) ;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h96);
    tick(3);
    check("bp_ok", n_ok, 1);
    check("bp_valid", pkt_valid, 1);
    check("bp_data_held", pkt_data, 8'h11);
    check("bp_last0", pkt_last, 0);
    send_byte(8'hA5);
    send_byte(8'h44);
    check("bp_data_after_ovr", pkt_data, 8'h11);
    check("bp_overrun", overrun_cnt, 8'd2);
    pkt_ready = 1'b1;
    tick(6);
    check("bp_ndata", cap_data.size(), 3);
    if (cap_data.size() == 3) begin
      check("bp_d0", cap_data[0], 8'h11);
      check("bp_d1", cap_data[1], 8'h22);
      check("bp_d2", cap_data[2], 8'h33);
      check("bp_lastflags", {cap_last[0], cap_last[1], cap_last[2]}, 3'b001);
    end
    check("bp_valid_end", pkt_valid, 0);

    // Reset in PAYLOAD after a baud change, then a normal frame.
    clear_caps();
    check("pre_rst_baud", baud_set, 3'd2);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    tick(1);
    check("midrst_outputs", outs_flat(), 32'h0);
    rst = 1'b0;
    tick(1);
    clear_caps();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'hCD);
    tick(10);
    check("postrst_ok", n_ok, 1);
    check("postrst_nerr", cap_code.size(), 0);
    check("postrst_ndata", cap_data.size(), 2);
    if (cap_data.size() == 2) check("postrst_data", {cap_data[0], cap_data[1]}, 16'h1020);

    // Randomized frames against the frame-level model.
    for (int f = 0; f < 40; f++) begin
      logic [7:0] cmd, len, chk, fr[$], pay[$], exp_data[$];
      int kind, sum, exp_ok, exp_code, exp_baud, cnt;
      kind = $urandom_range(0, 4);
      pay.delete(); fr.delete(); exp_data.delete();
      cmd = 8'h01; len = 8'h00; chk = 8'h00;
      case (kind)
        0, 2: begin cmd = 8'h01; len = 8'($urandom_range(0, 16)); end
        1:    begin cmd = 8'h02; len = 8'h01; end
        3:    begin
          cmd = 8'($urandom_range(0, 255));
          while (cmd == 8'h01 || cmd == 8'h02) cmd = 8'($urandom_range(0, 255));
        end
        default: begin
          if ($urandom_range(0, 1) == 1) begin cmd = 8'h01; len = 8'($urandom_range(17, 255)); end
          else begin
            cmd = 8'h02; len = 8'($urandom_range(0, 255));
            if (len == 8'h01) len = 8'h05;
          end
        end
      endcase
      if (kind <= 2) begin
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
        sum = cmd + len;
        foreach (pay[i]) sum += pay[i];
        chk = 8'((256 - (sum % 256)) % 256);
        if (kind == 2) chk = chk + 8'($urandom_range(1, 255));
      end
      fr.push_back(8'hA5);
      fr.push_back(cmd);
      if (kind != 3) fr.push_back(len);
      if (kind <= 2) begin foreach (pay[i]) fr.push_back(pay[i]); fr.push_back(chk); end

      exp_ok = 0; exp_code = 0; exp_baud = -1;
      if (cmd != 8'h01 && cmd != 8'h02) exp_code = 4;
      else if ((cmd == 8'h01 && len > 16) || (cmd == 8'h02 && len != 1)) exp_code = 1;
      else begin
        sum = cmd + len + chk;
        foreach (pay[i]) sum += pay[i];
        if (sum % 256 != 0) exp_code = 2;
        else begin
          exp_ok = 1;
          if (cmd == 8'h01) exp_data = pay;
          else exp_baud = (pay[0] % 8 <= 2) ? pay[0] % 8 : 0;
        end
      end

      clear_caps();
      foreach (fr[i]) send_byte(fr[i]);
      cnt = 0;
      while ((cnt < 5 || pkt_valid) && cnt < 300) begin
        pkt_ready = 1'($urandom_range(0, 1));
        tick(1);
        cnt++;
      end
      pkt_ready = 1'b1;
      tick(2);
      check($sformatf("rnd%0d_drained", f), pkt_valid, 0);
      check($sformatf("rnd%0d_ok", f), n_ok, exp_ok);
      check($sformatf("rnd%0d_nerr", f), cap_code.size(), (exp_code != 0) ? 1 : 0);
      if (exp_code != 0 && cap_code.size() > 0)
        check($sformatf("rnd%0d_code", f), cap_code[0], exp_code);
      check($sformatf("rnd%0d_ndata", f), cap_data.size(), exp_data.size());
      if (cap_data.size() == exp_data.size()) begin
        foreach (exp_data[i]) begin
          check($sformatf("rnd%0d_d%0d", f, i), cap_data[i], exp_data[i]);
          check($sformatf("rnd%0d_last%0d", f, i), cap_last[i], (i == exp_data.size() - 1) ? 1 : 0);
        end
      end
      check($sformatf("rnd%0d_nbaud", f), cap_baud.size(), (exp_baud >= 0) ? 1 : 0);
      if (exp_baud >= 0 && cap_baud.size() > 0)
        check($sformatf("rnd%0d_baud", f), cap_baud[0], exp_baud);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
